// File: rtl/imm_field_packer.sv
// imm_field_packer
//   Re-encodes a 64-bit signed offset into the immediate field of a LEGv8
//   instruction word. This is the inverse of the ID-stage sign extension.
//   fmt=0 selects the D-type field (DT_address) and fmt=1 selects the
//   CB-type field (COND_BR_address). The block is a two-stage valid/ready
//   pipeline with no skid buffer: stage 1 range-checks, stage 2 packs.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready depends combinationally
//                       on out_ready
//   in_fmt              0 = D-type, 1 = CB-type
//   in_value            signed offset to encode
//   in_instr            base instruction; the selected field is overwritten
//   out_valid/out_ready output handshake
//   out_instr           base instruction with the immediate field replaced
//   out_ovf             in_value did not fit the selected field; the field
//                       still receives the truncated low bits
//   err_clr             synchronous clear of err_count
//   err_count           saturating count of overflowed words sent downstream
module imm_field_packer #(
    parameter int unsigned D_LSB  = 12,
    parameter int unsigned D_W    = 9,
    parameter int unsigned CB_LSB = 5,
    parameter int unsigned CB_W   = 19,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [63:0]      in_value,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_ovf,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [31:0] D_ONES  = 32'((64'd1 << D_W) - 64'd1);
    localparam logic [31:0] CB_ONES = 32'((64'd1 << CB_W) - 64'd1);
    localparam logic [31:0] D_MASK  = D_ONES << D_LSB;
    localparam logic [31:0] CB_MASK = CB_ONES << CB_LSB;

    // Stage 1 (check) registers
    logic            s1_valid_q, s1_valid_d;
    logic            s1_fmt_q,   s1_fmt_d;
    logic [31:0]     s1_instr_q, s1_instr_d;
    logic [CB_W-1:0] s1_val_q,   s1_val_d;
    logic            s1_ovf_q,   s1_ovf_d;

    // Stage 2 (pack) registers, which are the outputs
    logic             s2_valid_q,  s2_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic             out_ovf_q,   out_ovf_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        s2_adv;
    logic        s1_adv;
    logic        in_xfer;
    logic        out_xfer;
    logic        d_fits;
    logic        cb_fits;
    logic [31:0] field_bits;
    logic [31:0] packed_instr;

    assign s2_adv   = out_ready || !s2_valid_q;
    assign s1_adv   = s1_valid_q && s2_adv;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

    // A value fits a W-bit signed field when bits [63:W-1] are a pure sign run.
    assign d_fits  = (&in_value[63:D_W-1])  || !(|in_value[63:D_W-1]);
    assign cb_fits = (&in_value[63:CB_W-1]) || !(|in_value[63:CB_W-1]);

    always_comb begin
        field_bits   = 32'(s1_val_q);
        packed_instr = s1_instr_q;
        if (s1_fmt_q) begin
            packed_instr = (s1_instr_q & ~CB_MASK) | ((field_bits & CB_ONES) << CB_LSB);
        end else begin
            packed_instr = (s1_instr_q & ~D_MASK) | ((field_bits & D_ONES) << D_LSB);
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fmt_d    = s1_fmt_q;
        s1_instr_d  = s1_instr_q;
        s1_val_d    = s1_val_q;
        s1_ovf_d    = s1_ovf_q;
        s2_valid_d  = s2_valid_q;
        out_instr_d = out_instr_q;
        out_ovf_d   = out_ovf_q;
        err_count_d = err_count_q;

        // When in_ready is high stage 1 is either empty or draining this
        // edge, so its valid simply follows in_valid.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_xfer) begin
            s1_fmt_d   = in_fmt;
            s1_instr_d = in_instr;
            s1_val_d   = in_value[CB_W-1:0];
            s1_ovf_d   = in_fmt ? !cb_fits : !d_fits;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            out_instr_d = packed_instr;
            out_ovf_d   = s1_ovf_q;
        end

        if (err_clr) begin
            err_count_d = '0;
        end else if (out_xfer && out_ovf_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 1'b0;
            s1_instr_q  <= '0;
            s1_val_q    <= '0;
            s1_ovf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_instr_q <= '0;
            out_ovf_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_instr_q  <= s1_instr_d;
            s1_val_q    <= s1_val_d;
            s1_ovf_q    <= s1_ovf_d;
            s2_valid_q  <= s2_valid_d;
            out_instr_q <= out_instr_d;
            out_ovf_q   <= out_ovf_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = out_instr_q;
    assign out_ovf   = out_ovf_q;
    assign err_count = err_count_q;

endmodule
